cordic_stream_packer: RTL
=========================

Name: cordic_stream_packer

Overview:
- Downstream stage of the CORDIC compute core inside the Zynq CORDIC system.
- Accepts one (cos, sin) result pair per handshake from the core.
- Buffers results in a small FIFO and packs each pair into one 32-bit AXI4-Stream beat.
- Asserts TLAST every frame_len beats so the AXI DMA write channel can return fixed-size frames to PS DDR.

Parameters:
- DATA_W, 16, width of each of cos and sin (signed fixed-point, passed through unmodified).
- FIFO_DEPTH, 4, number of buffered result pairs; power of two, at least 2.
- FRAME_LEN, 256, default beats per frame, used when cfg_frame_len is 0.

Ports:
- ap_clk  in  1  single clock for all logic.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- s_cos  in  DATA_W  cosine result from the CORDIC core.
- s_sin  in  DATA_W  sine result from the CORDIC core.
- s_valid  in  1  result pair valid.
- s_ready  out  1  packer can accept a pair.
- cfg_frame_len  in  16  beats per frame; 0 selects FRAME_LEN.
- m_axis_tdata  out  2*DATA_W  packed beat, {sin, cos}, with sin in the upper half.
- m_axis_tkeep  out  2*DATA_W/8  always all ones while tvalid=1.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  DMA ready.
- m_axis_tlast  out  1  last beat of the frame.
- frame_done  out  1  one-cycle pulse on the handshake of a TLAST beat.
- frames_sent  out  32  count of completed frames; wraps modulo 2^32.

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - FIFO emptied; beat counter = 0; len_q = FRAME_LEN; frames_sent = 0.
  - m_axis_tvalid/tdata/tlast/tkeep = 0; frame_done = 0; s_ready = 0.
  - Reset mid-frame discards the partial frame. The next frame starts at beat 0, with no TLAST emitted for the lost frame.
- After reset deassertion, s_ready = 1 from the first ap_clk edge.
- s_ready = !fifo_full. A push occurs when s_valid && s_ready.
  - A pair offered while full is held by the core and must not be lost or duplicated.
- Simultaneous push and pop: legal whenever not full; occupancy is unchanged.
- The output register is loaded from the FIFO head whenever it is empty or its beat is being accepted (m_axis_tvalid && m_axis_tready).
- Latency: a pair pushed in cycle N into an empty packer appears on m_axis in cycle N+1.
- Throughput: sustained 1 beat/cycle when m_axis_tready stays high.
- AXI4-Stream rules:
  - Once tvalid=1, tdata/tlast/tkeep hold stable and tvalid stays high until tready=1.
  - tvalid never depends combinationally on tready.
- Frame length: len_q loads from cfg_frame_len (0 maps to FRAME_LEN) only while beat counter = 0 and no beat is presented. Changes mid-frame take effect on the next frame.
- Beat counter:
  - Increments on each output handshake.
  - tlast = (counter == len_q-1) for the presented beat.
  - On a TLAST handshake: counter → 0, frame_done pulses for exactly that cycle, frames_sent increments.
- len_q = 1: every beat carries TLAST.
- Empty FIFO with tready=1 gives tvalid=0. Stalls never emit bubbles containing stale data.
- No arithmetic is performed on samples: bit-exact pass-through.

Decomposition:
- Shared package cordic_pkg holds:
  - DATA_W default;
  - the packed-beat typedef {sin, cos};
  - FRAME_LEN default;
  - the frame-length width constant.
- One sub-module is natural: cordic_sync_fifo, a parameterised width/depth synchronous FIFO with full/empty flags and async active-low reset. The packer instantiates it and adds the output register, framing counter and status.

Test Plan:
- Reset release, cfg_frame_len=4, push cos=16'h1000, sin=16'h0000 with tready=1 → beat 32'h0000_1000 in the next cycle, tkeep=4'hF, tlast=0.
- 8 back-to-back pairs, cfg_frame_len=4, tready=1 → 8 beats on consecutive cycles. TLAST on beats 3 and 7; frame_done pulses twice; frames_sent=2.
- tready=0 while pushing 6 pairs with FIFO_DEPTH=4 → s_ready falls after 4 FIFO pushes plus 1 in the output register; tdata held stable. On tready=1, all pairs drain in order with no loss or duplication.
- cfg_frame_len changed from 4 to 2 after beat 1 of a frame → current frame still ends on beat 3; the next frame ends after 2 beats.
- cfg_frame_len=0 → TLAST on beat 255; cfg_frame_len=1 → TLAST on every beat.
- ap_rst_n pulsed low mid-frame (beat 2 of 4) with tvalid=1 → tvalid drops asynchronously and frames_sent=0. The next frame's TLAST falls on its 4th beat after reset.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC output path.
// - DataWDefault    : default width of each of cos and sin
// - FrameLenDefault : beats per frame when the runtime frame length is 0
// - FrameLenW       : width of the runtime frame-length field and beat counter
// - beat_t          : packed output beat, sin in the upper half
package cordic_pkg;

  localparam int unsigned DataWDefault    = 16;
  localparam int unsigned FrameLenDefault = 256;
  localparam int unsigned FrameLenW       = 16;

  typedef struct packed {
    logic [DataWDefault-1:0] sin;
    logic [DataWDefault-1:0] cos;
  } beat_t;

endpackage

// File: rtl/cordic_stream_packer_if.sv
// Stream signals around the packer.
// - s_*      : (cos, sin) result pairs from the CORDIC core, valid/ready handshake
// - m_axis_* : packed AXI4-Stream beats towards the DMA write channel
// Modport slave is the packer's view; modport master is the surrounding system
// (core on the input side, DMA on the output side).
interface cordic_stream_packer_if #(
  parameter int unsigned DATA_W = cordic_pkg::DataWDefault
);

  logic [DATA_W-1:0]     s_cos;
  logic [DATA_W-1:0]     s_sin;
  logic                  s_valid;
  logic                  s_ready;
  logic [2*DATA_W-1:0]   m_axis_tdata;
  logic [2*DATA_W/8-1:0] m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport slave (
    input  s_cos, s_sin, s_valid, m_axis_tready,
    output s_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_cos, s_sin, s_valid, m_axis_tready,
    input  s_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/cordic_sync_fifo.sv
// Synchronous FIFO with full/empty flags.
// - clk_i, rst_ni : clock, asynchronous active-low reset (empties the FIFO)
// - push_i/data_i : write port, ignored while full
// - pop_i/data_o  : read port, data_o is the current head (valid when !empty_o)
// - full_o/empty_o: occupancy flags
// Depth must be a power of two and at least 2.
module cordic_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: it is only read while non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cordic_stream_packer.sv
// Packs CORDIC (cos, sin) result pairs into 32-bit AXI4-Stream beats with framing.
// - ap_clk, ap_rst_n : clock, asynchronous active-low reset
// - bus              : input pair handshake and AXI4-Stream output (slave modport)
// - cfg_frame_len    : beats per frame, 0 selects FRAME_LEN; sampled between frames
// - frame_done       : pulses in the cycle a TLAST beat is accepted
// - frames_sent      : completed-frame counter, wraps
module cordic_stream_packer
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAME_LEN  = FrameLenDefault
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  cordic_stream_packer_if.slave bus,
  input  logic [FrameLenW-1:0] cfg_frame_len,
  output logic                 frame_done,
  output logic [31:0]          frames_sent
);

  localparam int unsigned          BeatW  = 2 * DATA_W;
  localparam logic [FrameLenW-1:0] DefLen = FrameLenW'(FRAME_LEN);
  localparam logic [FrameLenW-1:0] One    = FrameLenW'(1);

  logic                 ready_q;
  logic [BeatW-1:0]     tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic [FrameLenW-1:0] cnt_q, cnt_d;
  logic [FrameLenW-1:0] len_q, len_d;
  logic [31:0]          frames_q, frames_d;

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [BeatW-1:0] fifo_rdata, in_beat;
  logic             push, load_en, hs, tlast;

  assign in_beat = {bus.s_sin, bus.s_cos};

  // ready_q keeps s_ready low during reset and raises it on the first edge after.
  assign bus.s_ready = ready_q && !fifo_full;
  assign push        = bus.s_valid && bus.s_ready;

  // The output register refills whenever it is empty or its beat is leaving.
  assign load_en = !tvalid_q || bus.m_axis_tready;
  assign hs      = tvalid_q && bus.m_axis_tready;

  // With the FIFO empty a pushed pair bypasses it straight into the output
  // register, giving one-cycle latency; otherwise it queues behind the head.
  assign fifo_pop  = load_en && !fifo_empty;
  assign fifo_push = push && !(load_en && fifo_empty);

  cordic_sync_fifo #(
    .Width (BeatW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .push_i  (fifo_push),
    .data_i  (in_beat),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tlast = tvalid_q && (cnt_q == len_q - One);

  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast;
  assign bus.m_axis_tkeep  = {(BeatW / 8){tvalid_q}};
  assign frame_done        = hs && tlast;
  assign frames_sent       = frames_q;

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    frames_d = frames_q;

    if (load_en) begin
      if (!fifo_empty) begin
        tvalid_d = 1'b1;
        tdata_d  = fifo_rdata;
      end else if (push) begin
        tvalid_d = 1'b1;
        tdata_d  = in_beat;
      end else begin
        tvalid_d = 1'b0;
        tdata_d  = '0;
      end
    end

    if (hs) cnt_d = tlast ? '0 : cnt_q + One;

    // Frame length only changes between frames, never under a presented beat.
    if (cnt_q == '0 && !tvalid_q) len_d = (cfg_frame_len == '0) ? DefLen : cfg_frame_len;

    if (frame_done) frames_d = frames_q + 32'd1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ready_q  <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      cnt_q    <= '0;
      len_q    <= DefLen;
      frames_q <= '0;
    end else begin
      ready_q  <= 1'b1;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      frames_q <= frames_d;
    end
  end

endmodule
